// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory with byte/halfword/word access.
// A request is serviced at its acceptance edge. The formatted result goes into
// a two-entry response FIFO, so the requester can stay one response ahead of
// a stalled consumer.
module dmem_responder #(
    parameter int N_BITS      = 32,
    parameter int DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_vld,
    output logic              req_rdy,
    input  logic [N_BITS-1:0] req_addr,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [N_BITS-1:0] req_wdata,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [N_BITS-1:0] rsp_data,
    output logic              rsp_err
);
    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int LANES = N_BITS / 8;

    logic [AW-1:0]     word_idx;
    logic [N_BITS-1:0] rd_word;
    logic              accept;
    logic              pop;
    logic              req_err;
    logic              store_en;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [N_BITS-1:0] load_data;
    logic [N_BITS-1:0] push_data;

    // Two-entry response FIFO with 1-bit wrapping pointers.
    logic [N_BITS-1:0] fifo_data_reg [2];
    logic              fifo_err_reg  [2];
    logic              wr_ptr_reg;
    logic              rd_ptr_reg;
    logic [1:0]        occ_reg;

    assign word_idx = req_addr[AW+1:2];
    assign accept   = req_vld && req_rdy;
    assign pop      = rsp_vld && rsp_rdy;
    assign store_en = accept && req_wen && !req_err;

    // Illegal size, misalignment, or a word index beyond the backing array.
    always_comb begin
        req_err = 1'b0;
        if (req_size == 2'b11)
            req_err = 1'b1;
        if (req_size == 2'b01 && req_addr[0])
            req_err = 1'b1;
        if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
        if (|req_addr[N_BITS-1:AW+2])
            req_err = 1'b1;
    end

    // One byte-wide array per lane so stores only touch the addressed lanes.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE_SEL = 2'(gi % 4);
            localparam logic       LANE_HI  = 1'((gi / 2) % 2);
            localparam int         HALF_OFS = (gi % 2) * 8;

            logic [7:0] lane_mem [DEPTH_WORDS];
            logic       lane_we;
            logic [7:0] lane_wdata;

            // Lane write enable and data select for the current store size.
            always_comb begin
                lane_we    = 1'b0;
                lane_wdata = req_wdata[gi*8 +: 8];
                case (req_size)
                    2'b00: begin
                        lane_we    = store_en && (req_addr[1:0] == LANE_SEL) && (gi < 4);
                        lane_wdata = req_wdata[7:0];
                    end
                    2'b01: begin
                        lane_we    = store_en && (req_addr[1] == LANE_HI) && (gi < 4);
                        lane_wdata = req_wdata[HALF_OFS +: 8];
                    end
                    default: lane_we = store_en;
                endcase
            end

            // Lane storage; contents intentionally survive reset.
            always_ff @(posedge clk) begin
                if (lane_we)
                    lane_mem[word_idx] <= lane_wdata;
            end

            assign rd_word[gi*8 +: 8] = lane_mem[word_idx];
        end
    endgenerate

    assign byte_sel = rd_word[{req_addr[1:0], 3'b000} +: 8];
    assign half_sel = rd_word[{req_addr[1], 4'b0000} +: 16];

    // Extract and extend the load result; stores and errors respond with zero.
    always_comb begin
        case (req_size)
            2'b00:   load_data = {{(N_BITS-8){~req_unsigned & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{(N_BITS-16){~req_unsigned & half_sel[15]}}, half_sel};
            default: load_data = rd_word;
        endcase
        push_data = '0;
        if (!req_err && !req_wen)
            push_data = load_data;
    end

    // FIFO payload storage, written at the acceptance edge.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_data_reg[wr_ptr_reg] <= push_data;
            fifo_err_reg[wr_ptr_reg]  <= req_err;
        end
    end

    // FIFO pointers and occupancy; reset drops every queued response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            occ_reg    <= 2'd0;
        end else begin
            if (accept)
                wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)
                rd_ptr_reg <= ~rd_ptr_reg;
            case ({accept, pop})
                2'b10:   occ_reg <= occ_reg + 2'd1;
                2'b01:   occ_reg <= occ_reg - 2'd1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    assign req_rdy  = !rst && (occ_reg != 2'd2);
    assign rsp_vld  = (occ_reg != 2'd0);
    assign rsp_data = rsp_vld ? fifo_data_reg[rd_ptr_reg] : '0;
    assign rsp_err  = rsp_vld ? fifo_err_reg[rd_ptr_reg] : 1'b0;

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed scenarios plus randomized traffic,
// checked against a byte-addressed memory model and an expected-response queue.
module tb_dmem_responder;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic [31:0] req_addr = '0;
    logic        req_wen = 1'b0;
    logic [1:0]  req_size = 2'b10;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b0;
    logic [31:0] rsp_data;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t       exp_q[$];
    logic [7:0] mem_b [DEPTH*4];

    dmem_responder #(.N_BITS(32), .DEPTH_WORDS(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_addr     (req_addr),
        .req_wen      (req_wen),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .rsp_vld      (rsp_vld),
        .rsp_rdy      (rsp_rdy),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    // Reference behaviour of one accepted request on a flat byte memory.
    function automatic void model_req(logic [31:0] addr, bit wen, logic [1:0] size,
                                      bit uns, logic [31:0] wdata);
        rsp_t r;
        int   nbytes;
        int   bits;
        logic [31:0] v;
        r.data = '0;
        r.err  = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
                 (size == 2'd2 && addr % 4 != 0) || ((addr / 4) >= DEPTH);
        if (!r.err) begin
            nbytes = 1 << size;
            if (wen) begin
                for (int k = 0; k < nbytes; k++)
                    mem_b[int'(addr) + k] = wdata[8*k +: 8];
            end else begin
                v = '0;
                for (int k = 0; k < nbytes; k++)
                    v = v | (32'(mem_b[int'(addr) + k]) << (8*k));
                bits = 8 * nbytes;
                if (!uns && nbytes < 4 && v[bits-1])
                    v = v | (32'hFFFF_FFFF << bits);
                r.data = v;
            end
        end
        exp_q.push_back(r);
    endfunction

    // Drive one cycle from a falling edge; returns whether the request was accepted.
    task automatic tick(input bit vld, input logic [31:0] addr, input bit wen,
                        input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                        input bit rrdy, output bit acc);
        bit popd;
        req_vld = vld; req_addr = addr; req_wen = wen; req_size = size;
        req_unsigned = uns; req_wdata = wdata; rsp_rdy = rrdy;
        #1;
        acc  = vld && req_rdy;
        popd = rsp_vld && rrdy;
        @(posedge clk);
        if (popd && exp_q.size() > 0)
            void'(exp_q.pop_front());
        if (acc)
            model_req(addr, wen, size, uns, wdata);
        @(negedge clk);
        req_vld = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++;
        if (req_rdy !== 1'b0 || rsp_vld !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%h err=%b required 0/0/0/0",
                     req_rdy, rsp_vld, rsp_data, rsp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_rdy: got %b required 1", req_rdy);
        end
        $display("test_reset done");
    endtask

    task automatic test_init();
        bit acc;
        int bad = 0;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            tick(1'b1, 32'(i*4), 1'b1, 2'd2, 1'b0, $urandom, 1'b1, acc);
            checks++;
            if (!acc || rsp_vld !== 1'b1 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
                errors++;
                bad++;
                if (bad < 5)
                    $display("FAIL init_store[%0d]: acc=%b vld=%b data=%h err=%b required 1/1/0/0",
                             i, acc, rsp_vld, rsp_data, rsp_err);
            end
        end
        tick(1'b0, '0, 1'b0, 2'd0, 1'b0, '0, 1'b1, acc);
        $display("test_init: %0d word stores", DEPTH);
    endtask

    task automatic test_store_load();
        bit acc;
        tick(1'b1, 32'h10, 1'b1, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b1, acc);
        checks++;
        if (!acc || rsp_vld !== 1'b1 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL store_word_rsp: acc=%b vld=%b data=%h err=%b required 1/1/0/0",
                     acc, rsp_vld, rsp_data, rsp_err);
        end
        tick(1'b1, 32'h10, 1'b0, 2'd2, 1'b0, '0, 1'b1, acc);
        checks++;
        if (rsp_vld !== 1'b1 || rsp_data !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL load_word: vld=%b data=%h err=%b required 1/deadbeef/0", rsp_vld, rsp_data, rsp_err);
        end
        tick(1'b1, 32'h13, 1'b0, 2'd0, 1'b0, '0, 1'b1, acc);
        checks++;
        if (rsp_data !== 32'hFFFF_FFDE || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL load_byte_signed: data=%h err=%b required ffffffde/0", rsp_data, rsp_err);
        end
        tick(1'b1, 32'h13, 1'b0, 2'd0, 1'b1, '0, 1'b1, acc);
        checks++;
        if (rsp_data !== 32'h0000_00DE || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL load_byte_unsigned: data=%h err=%b required 000000de/0", rsp_data, rsp_err);
        end
        tick(1'b1, 32'h12, 1'b0, 2'd1, 1'b0, '0, 1'b1, acc);
        checks++;
        if (rsp_data !== 32'hFFFF_DEAD || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL load_half_signed: data=%h err=%b required ffffdead/0", rsp_data, rsp_err);
        end
        tick(1'b0, '0, 1'b0, 2'd0, 1'b0, '0, 1'b1, acc);
        checks++;
        if (rsp_vld !== 1'b0) begin
            errors++;
            $display("FAIL store_load_drain: vld=%b required 0", rsp_vld);
        end
        $display("test_store_load done");
    endtask

    task automatic test_back_to_back();
        bit acc1, acc2, acc3, acc4, acc5;
        logic [31:0] hold;
        tick(1'b1, 32'h40, 1'b0, 2'd2, 1'b0, '0, 1'b0, acc1);
        tick(1'b1, 32'h44, 1'b0, 2'd2, 1'b0, '0, 1'b0, acc2);
        hold = rsp_data;
        tick(1'b1, 32'h48, 1'b0, 2'd2, 1'b0, '0, 1'b0, acc3);
        #1;
        checks++;
        if (!acc1 || !acc2 || acc3 || req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accepts: acc=%b%b%b rdy=%b required 110 rdy 0", acc1, acc2, acc3, req_rdy);
        end
        checks++;
        if (rsp_data !== hold || rsp_data !== exp_q[0].data) begin
            errors++;
            $display("FAIL b2b_head_stable: data=%h required %h", rsp_data, exp_q[0].data);
        end
        @(negedge clk);
        tick(1'b1, 32'h48, 1'b0, 2'd2, 1'b0, '0, 1'b1, acc4);
        checks++;
        if (acc4 || rsp_data !== exp_q[0].data) begin
            errors++;
            $display("FAIL b2b_first_pop: acc=%b data=%h required acc 0 data %h", acc4, rsp_data, exp_q[0].data);
        end
        tick(1'b1, 32'h48, 1'b0, 2'd2, 1'b0, '0, 1'b1, acc5);
        checks++;
        if (!acc5) begin
            errors++;
            $display("FAIL b2b_third_accept: acc=%b required 1", acc5);
        end
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            checks++;
            if (rsp_vld !== 1'b1 || rsp_data !== exp_q[0].data) begin
                errors++;
                $display("FAIL b2b_drain[%0d]: vld=%b data=%h required 1/%h", i, rsp_vld, rsp_data, exp_q[0].data);
            end
            tick(1'b0, '0, 1'b0, 2'd0, 1'b0, '0, 1'b1, acc1);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_errors();
        bit acc;
        logic [31:0] e_addr [5] = '{32'h02, 32'h01, 32'h10, 32'(DEPTH*4), 32'h12};
        bit          e_wen  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [1:0]  e_size [5] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd2};
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, e_addr[i], e_wen[i], e_size[i], 1'b0, 32'h1234_5678, 1'b1, acc);
            checks++;
            if (!acc || rsp_vld !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 32'h0) begin
                errors++;
                $display("FAIL err_req[%0d]: acc=%b vld=%b err=%b data=%h required 1/1/1/0",
                         i, acc, rsp_vld, rsp_err, rsp_data);
            end
        end
        tick(1'b1, 32'h10, 1'b0, 2'd2, 1'b0, '0, 1'b1, acc);
        checks++;
        if (rsp_data !== 32'hDEAD_BEEF || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL err_array_10: data=%h err=%b required deadbeef/0", rsp_data, rsp_err);
        end
        tick(1'b1, 32'h00, 1'b0, 2'd2, 1'b0, '0, 1'b1, acc);
        checks++;
        if (rsp_data !== exp_q[0].data || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL err_array_00: data=%h err=%b required %h/0", rsp_data, rsp_err, exp_q[0].data);
        end
        tick(1'b0, '0, 1'b0, 2'd0, 1'b0, '0, 1'b1, acc);
        $display("test_errors done");
    endtask

    task automatic test_random();
        bit acc;
        logic [31:0] addr;
        logic [1:0]  size;
        int bad = 0;
        for (int n = 0; n < 400; n++) begin
            #1;
            checks++;
            if (rsp_vld !== (exp_q.size() != 0) || req_rdy !== (exp_q.size() < 2) ||
                (exp_q.size() != 0 && (rsp_data !== exp_q[0].data || rsp_err !== exp_q[0].err))) begin
                errors++;
                bad++;
                if (bad < 6)
                    $display("FAIL rand[%0d]: vld=%b rdy=%b data=%h err=%b required vld=%b rdy=%b data=%h err=%b",
                             n, rsp_vld, req_rdy, rsp_data, rsp_err, exp_q.size() != 0, exp_q.size() < 2,
                             exp_q.size() != 0 ? exp_q[0].data : 32'h0,
                             exp_q.size() != 0 ? exp_q[0].err : 1'b0);
            end
            if ($urandom_range(15) == 0)
                addr = 32'(DEPTH*4) + 32'($urandom_range(1023));
            else
                addr = 32'($urandom_range(DEPTH-1) * 4 + $urandom_range(3));
            size = ($urandom_range(15) == 0) ? 2'd3 : 2'($urandom_range(2));
            tick($urandom_range(3) != 0, addr, 1'($urandom), size, 1'($urandom), $urandom,
                 $urandom_range(2) != 0, acc);
        end
        for (int i = 0; i < 3; i++)
            tick(1'b0, '0, 1'b0, 2'd0, 1'b0, '0, 1'b1, acc);
        $display("test_random: 400 cycles");
    endtask

    task automatic test_reset_mid();
        bit acc;
        tick(1'b1, 32'h20, 1'b1, 2'd2, 1'b0, 32'hCAFE_F00D, 1'b1, acc);
        tick(1'b1, 32'h20, 1'b0, 2'd2, 1'b0, '0, 1'b0, acc);
        tick(1'b1, 32'h24, 1'b0, 2'd2, 1'b0, '0, 1'b0, acc);
        checks++;
        if (rsp_vld !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_queued: vld=%b required 1", rsp_vld);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_vld !== 1'b0 || req_rdy !== 1'b0 || rsp_data !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_flush: vld=%b rdy=%b data=%h required 0/0/0", rsp_vld, req_rdy, rsp_data);
        end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        tick(1'b1, 32'h20, 1'b0, 2'd2, 1'b0, '0, 1'b1, acc);
        checks++;
        if (!acc || rsp_vld !== 1'b1 || rsp_data !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL rstmid_persist: acc=%b vld=%b data=%h required 1/1/cafef00d", acc, rsp_vld, rsp_data);
        end
        tick(1'b0, '0, 1'b0, 2'd0, 1'b0, '0, 1'b1, acc);
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_init();
        test_store_load();
        test_back_to_back();
        test_errors();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
